// File: rtl/sys_defs.sv
// Shared bus definitions for the processor-memory interface: command
// encoding, memory tag sizing and the load-return pipeline entry.
package sys_defs;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  localparam int MEM_TAG_W    = 4;
  localparam int NUM_MEM_TAGS = 15;

  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] tag;
    logic [63:0]          data;
  } mem_pipe_entry_t;

  // Round-robin successor of a tag: 1..15, wrapping 15 -> 1 and skipping 0.
  function automatic logic [MEM_TAG_W-1:0] next_tag(input logic [MEM_TAG_W-1:0] t);
    return (t == MEM_TAG_W'(NUM_MEM_TAGS)) ? MEM_TAG_W'(1) : t + MEM_TAG_W'(1);
  endfunction

endpackage

// File: rtl/mem_tag_alloc.sv
// Response tag allocator: busy mask over tags 1..15, round-robin pointer,
// first-free pick starting at the pointer, set on load issue and release
// on load completion.
module mem_tag_alloc
  import sys_defs::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 request,    // command present and allowed this cycle
  input  logic                 set_busy,   // the request is a load (holds its tag)
  input  logic                 rel_valid,  // a load completes this cycle
  input  logic [MEM_TAG_W-1:0] rel_tag,
  output logic [MEM_TAG_W-1:0] grant_tag   // 0 = not accepted
);

  logic [NUM_MEM_TAGS:1] busy;
  logic [NUM_MEM_TAGS:1] busy_next;
  logic [NUM_MEM_TAGS:1] busy_view;
  logic [MEM_TAG_W-1:0]  ptr;
  logic [MEM_TAG_W-1:0]  pick;
  logic [MEM_TAG_W-1:0]  scan;

  // The pick logic reads the mask through this net so a full mask can be
  // imposed from outside without disturbing the stored state.
  assign busy_view = busy;

  // Scan from the pointer with wrap; take the first tag that is not busy.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    pick = '0;
    scan = ptr;
    for (int i = 0; i < NUM_MEM_TAGS; i++) begin
      if (pick == '0 && !busy_view[scan]) pick = scan;
      scan = next_tag(scan);
    end
    grant_tag = request ? pick : '0;
  end

  // Next mask: a completing tag is freed, a newly issued load tag is held.
  always_comb begin
    busy_next = busy;
    if (rel_valid) busy_next[rel_tag] = 1'b0;
    if (set_busy && grant_tag != '0) busy_next[grant_tag] = 1'b1;
  end

  // Mask and pointer registers; pointer moves past every granted tag.
  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      busy <= '0;
      ptr  <= MEM_TAG_W'(1);
    end else begin
      busy <= busy_next;
      if (grant_tag != '0) ptr <= next_tag(grant_tag);
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Responder end of the processor-memory bus. Accepts loads and stores,
// answers with a nonzero tag in the same cycle, and returns load data with
// its tag LATENCY cycles later.
// Optional build macro MEM_RAND_STALL_EN: an 8-bit LFSR rejects requests
// pseudo-randomly to exercise initiator retry paths.
module mem_responder
  import sys_defs::*;
#(
  parameter int LATENCY   = 10,   // 1..14
  parameter int MEM_WORDS = 8192, // power of 2
  parameter int IDX_BITS  = $clog2(MEM_WORDS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  bus_command_t         proc2mem_command,
  input  logic [XLEN-1:0]      proc2mem_addr,
  input  logic [63:0]          proc2mem_data,
  output logic [MEM_TAG_W-1:0] mem2proc_response,
  output logic [63:0]          mem2proc_data,
  output logic [MEM_TAG_W-1:0] mem2proc_tag
);

  logic [63:0]         mem [MEM_WORDS];
  logic [IDX_BITS-1:0] word_idx;
  logic [63:0]         rd_data;
  logic                stall_ok;
  logic                request;
  logic                acc_load;
  logic                acc_store;
  mem_pipe_entry_t     new_entry;
  mem_pipe_entry_t     pipe [LATENCY];
  logic                unused_addr_bits;

  // Offset bits and aliasing upper bits do not take part in addressing.
  assign word_idx         = proc2mem_addr[IDX_BITS+2:3];
  assign unused_addr_bits = ^{proc2mem_addr[2:0], proc2mem_addr[XLEN-1:IDX_BITS+3]};

`ifdef MEM_RAND_STALL_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR, taps 8,6,5,4; one step per non-reset cycle.
  always_ff @(posedge clock) begin
    if (reset) lfsr <= 8'h01;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign stall_ok = (lfsr[1:0] != 2'b00);
`else
  assign stall_ok = 1'b1;
`endif

  assign request = !reset && (proc2mem_command != BUS_NONE) && stall_ok;

  mem_tag_alloc u_alloc (
    .clock     (clock),
    .reset     (reset),
    .request   (request),
    .set_busy  (proc2mem_command == BUS_LOAD),
    .rel_valid (pipe[LATENCY-1].valid),
    .rel_tag   (pipe[LATENCY-1].tag),
    .grant_tag (mem2proc_response)
  );

  assign acc_load  = (mem2proc_response != '0) && (proc2mem_command == BUS_LOAD);
  assign acc_store = (mem2proc_response != '0) && (proc2mem_command == BUS_STORE);
  assign rd_data   = mem[word_idx];

  // Build the pipeline entry; idle slots carry zero tag and zero data.
  always_comb begin
    new_entry       = '0;
    new_entry.valid = acc_load;
    if (acc_load) begin
      new_entry.tag  = mem2proc_response;
      new_entry.data = rd_data;
    end
  end

  // Backing-store write on an accepted store.
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset branch on purpose; contents survive reset
    // and the array maps onto plain RAM.
    if (acc_store) mem[word_idx] <= proc2mem_data;
  end

  // LATENCY-deep return pipeline; reset drops every in-flight load.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= new_entry;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign mem2proc_tag  = pipe[LATENCY-1].tag;
  assign mem2proc_data = pipe[LATENCY-1].data;

endmodule
